// File: rtl/aurora_tx_framer.sv
// rtl/aurora_tx_framer.sv - Aurora TX frame builder: header, payload, tail (bytecnt + checksum); macro AURORA_TX_FRAMER_STATS_EN enables counters
module aurora_tx_framer #(
  parameter logic [15:0] P_MAGIC     = 16'hA5C3,
  parameter logic [7:0]  P_CHAN_ID   = 8'h00,
  parameter int          P_MAX_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_channel_up,
  input  logic [31:0] i_user_data,
  input  logic [3:0]  i_user_keep,
  input  logic        i_user_last,
  input  logic        i_user_valid,
  output logic        o_user_ready,
  output logic [0:31] o_tx_tdata,
  output logic [0:3]  o_tx_tkeep,
  output logic        o_tx_tlast,
  output logic        o_tx_tvalid,
  input  logic        i_tx_tready,
  output logic        o_abort,
  output logic        o_oversize,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_DATA, S_TAIL, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [0:31] tdata_q, tdata_d;
  logic [0:3]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tvalid_q, tvalid_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] bytecnt_q, bytecnt_d;
  logic [15:0] csum_q, csum_d;
  logic [13:0] wcnt_q, wcnt_d;
  logic        ovf_q, ovf_d;
  logic        abort_q, abort_d;
  logic        oversize_q, oversize_d;

  logic        reg_free;
  logic [3:0]  eff_keep;
  logic [31:0] masked;
  logic [2:0]  beat_bytes;
  logic [15:0] beat_sum;
  logic        user_ready;

  assign reg_free = !tvalid_q || i_tx_tready;

  // Per-beat contribution to byte count and checksum; keep is forced full except on the last beat
  always_comb begin
    eff_keep   = i_user_last ? i_user_keep : 4'hF;
    masked     = {eff_keep[3] ? i_user_data[31:24] : 8'h00,
                  eff_keep[2] ? i_user_data[23:16] : 8'h00,
                  eff_keep[1] ? i_user_data[15:8]  : 8'h00,
                  eff_keep[0] ? i_user_data[7:0]   : 8'h00};
    beat_bytes = {2'b00, eff_keep[3]} + {2'b00, eff_keep[2]} +
                 {2'b00, eff_keep[1]} + {2'b00, eff_keep[0]};
    beat_sum   = masked[31:16] + masked[15:0];
  end

  // Next-state, output register loading and frame accounting
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    seq_d      = seq_q;
    bytecnt_d  = bytecnt_q;
    csum_d     = csum_q;
    wcnt_d     = wcnt_q;
    ovf_d      = ovf_q;
    abort_d    = 1'b0;
    oversize_d = 1'b0;
    user_ready = 1'b0;

    // A presented word leaves the register on handshake; a load below overrides this
    if (tvalid_q && i_tx_tready) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_user_valid && i_channel_up) begin
          state_d = S_HEAD;
        end
      end

      S_HEAD: begin
        if (!i_channel_up) begin
          state_d = S_DROP;
        end else if (reg_free) begin
          tdata_d  = {P_MAGIC, seq_q, P_CHAN_ID};
          tkeep_d  = 4'hF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          wcnt_d   = '0;
          state_d  = S_DATA;
        end
      end

      S_DATA: begin
        // Ready is withheld on link loss so no beat slips in during the abort cycle
        if (!i_channel_up) begin
          state_d = S_DROP;
        end else begin
          user_ready = reg_free;
          if (i_user_valid && reg_free) begin
            tdata_d   = i_user_data;
            tkeep_d   = eff_keep;
            tlast_d   = 1'b0;
            tvalid_d  = 1'b1;
            bytecnt_d = bytecnt_q + {13'd0, beat_bytes};
            csum_d    = csum_q + beat_sum;
            wcnt_d    = wcnt_q + 14'd1;
            if (i_user_last) begin
              ovf_d   = 1'b0;
              state_d = S_TAIL;
            end else if (wcnt_q == 14'(P_MAX_WORDS - 1)) begin
              ovf_d      = 1'b1;
              oversize_d = 1'b1;
              state_d    = S_TAIL;
            end
          end
        end
      end

      S_TAIL: begin
        // Register holding a tlast word means the tail is already loaded
        if (!i_channel_up) begin
          state_d = ovf_q ? S_DROP : S_IDLE;
        end else if (tvalid_q && tlast_q) begin
          if (i_tx_tready) begin
            seq_d     = seq_q + 8'd1;
            bytecnt_d = '0;
            csum_d    = '0;
            ovf_d     = 1'b0;
            state_d   = ovf_q ? S_DROP : S_IDLE;
          end
        end else if (reg_free) begin
          tdata_d  = {bytecnt_q, csum_q};
          tkeep_d  = 4'hF;
          tlast_d  = 1'b1;
          tvalid_d = 1'b1;
        end
      end

      S_DROP: begin
        user_ready = 1'b1;
        if (i_user_valid && i_user_last) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Link loss inside a frame: flush the output and forget the partial frame
    if (!i_channel_up && (state_q == S_HEAD || state_q == S_DATA || state_q == S_TAIL)) begin
      abort_d   = 1'b1;
      tvalid_d  = 1'b0;
      tlast_d   = 1'b0;
      bytecnt_d = '0;
      csum_d    = '0;
      ovf_d     = 1'b0;
    end
  end

  // State and output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      seq_q      <= '0;
      bytecnt_q  <= '0;
      csum_q     <= '0;
      wcnt_q     <= '0;
      ovf_q      <= 1'b0;
      abort_q    <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      seq_q      <= seq_d;
      bytecnt_q  <= bytecnt_d;
      csum_q     <= csum_d;
      wcnt_q     <= wcnt_d;
      ovf_q      <= ovf_d;
      abort_q    <= abort_d;
      oversize_q <= oversize_d;
    end
  end

  assign o_user_ready = user_ready;
  assign o_tx_tdata   = tdata_q;
  assign o_tx_tkeep   = tkeep_q;
  assign o_tx_tlast   = tlast_q;
  assign o_tx_tvalid  = tvalid_q;
  assign o_abort      = abort_q;
  assign o_oversize   = oversize_q;

`ifdef AURORA_TX_FRAMER_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        tail_done;
  logic        drop_beat;

  assign tail_done = (state_q == S_TAIL) && i_channel_up && tvalid_q && tlast_q && i_tx_tready;
  assign drop_beat = (state_q == S_DROP) && i_user_valid;

  // Frame counter wraps; drop counter saturates
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (tail_done) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
    if (drop_beat && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`else
  assign o_frame_cnt = '0;
  assign o_drop_cnt  = '0;
`endif

endmodule
